// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: assembles 32-bit little-endian words from an 8-bit memory port.
// Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirects in a FAULT state instead of masking them.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_rvalid,
   input  logic [7:0]            mem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [31:0]           instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;
`else
   typedef enum logic {FETCH, HOLD} state_t;
`endif

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic [1:0]            byte_idx;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic                  redirect_misaligned;
   logic                  capture;
   logic                  accept;

`ifdef FETCH_ALIGN_CHECK_EN
   assign redirect_target     = redirect_pc;
   assign redirect_misaligned = |redirect_pc[1:0];
`else
   logic unused_redirect_low;
   assign unused_redirect_low = ^redirect_pc[1:0];
   assign redirect_target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign redirect_misaligned = 1'b0;
`endif

   // A redirect in the same cycle suppresses both byte capture and the pc+4 step.
   assign capture = (state == FETCH) && mem_rvalid && !redirect_valid;
   assign accept  = (state == HOLD) && instr_ready && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      mem_req     = 1'b0;
      instr_valid = 1'b0;
      fetch_fault = 1'b0;
      if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
         state_next = redirect_misaligned ? FAULT : FETCH;
`else
         state_next = FETCH;
`endif
      end else begin
         case (state)
            FETCH: if (mem_rvalid && (byte_idx == 2'd3)) state_next = HOLD;
            HOLD:  if (instr_ready) state_next = FETCH;
            default: state_next = state;
         endcase
      end
      // Reset forces the state to FETCH, so rst_n gates the request directly.
      mem_req     = rst_n && (state == FETCH);
      instr_valid = (state == HOLD);
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_fault = (state == FAULT);
`endif
   end

   assign mem_addr = pc + {{(ADDR_WIDTH-2){1'b0}}, byte_idx};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= ADDR_WIDTH'(RESET_PC);
         byte_idx   <= '0;
         instr_data <= '0;
         instr_pc   <= '0;
      end else if (redirect_valid) begin
         pc       <= redirect_target;
         byte_idx <= '0;
      end else if (capture) begin
         instr_data[{byte_idx, 3'b000} +: 8] <= mem_rdata;
         byte_idx                            <= byte_idx + 2'd1;
         if (byte_idx == 2'd3) begin
            instr_pc <= pc;
         end
      end else if (accept) begin
         pc <= pc + ADDR_WIDTH'(4);
      end
   end

endmodule
